// File: rtl/fft_pkg.sv
// Shared types, Q1.15 constants and helper functions for the radix-2 FFT sequencer.
// Holds the quarter-wave cosine table from which all N<=64 twiddles are derived.
package fft_pkg;

  localparam int MAX_LOG2N = 6;

  typedef logic [MAX_LOG2N-1:0] addr_t;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } sample_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_UNLOAD
  } state_t;

  localparam logic signed [15:0] ONE     = 16'sh7fff;
  localparam logic signed [15:0] NEG_ONE = 16'sh8001;

  // round(32768*cos(2*pi*k/64)) for k = 0..16, saturated to ONE at k = 0.
  localparam logic signed [15:0] COS_Q [17] = '{
    ONE,        16'sh7f62, 16'sh7d8a, 16'sh7a7d,
    16'sh7642,  16'sh70e3, 16'sh6a6e, 16'sh62f2,
    16'sh5a82,  16'sh5134, 16'sh471d, 16'sh3c57,
    16'sh30fc,  16'sh2528, 16'sh18f9, 16'sh0c8c,
    16'sh0000
  };

  // Reverses the low 'bits' bits of i; upper bits of the result are zero.
  function automatic addr_t bitrev(input addr_t i, input int bits);
    addr_t r;
    addr_t v;
    r = '0;
    v = i;
    for (int n = 0; n < MAX_LOG2N; n++) begin
      if (n < bits) begin
        r = {r[MAX_LOG2N-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

  // W_64^k for k = 0..31, folded onto the first quadrant of the cosine table.
  function automatic sample_t tw64(input logic [4:0] k);
    sample_t t;
    if (k <= 5'd16) begin
      t.re = COS_Q[k];
      t.im = -COS_Q[5'd16 - k];
    end else begin
      t.re = -COS_Q[5'd0 - k];
      t.im = -COS_Q[k - 5'd16];
    end
    return t;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup: index k (0..N/2-1) -> W_N^k in Q1.15.
// W_N^k equals W_64^(k*64/N), so the 64-point table serves every legal N.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [$clog2(N)-2:0] k,
  output sample_t              tw
);

  localparam int LOG2N = $clog2(N);

  logic [4:0] k64;

  assign k64 = 5'(k) << (MAX_LOG2N - LOG2N);
  assign tw  = tw64(k64);

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: loads samples in bit-reversed order, issues one
// butterfly per cycle to an external BFU, writes results back, then streams bins out.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int N       = 8,
  parameter int BFU_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_real,
  input  logic signed [15:0] in_imag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_real,
  output logic signed [15:0] out_imag,
  output logic               out_last,
  output logic               bfu_valid,
  output logic signed [15:0] g_real,
  output logic signed [15:0] g_imag,
  output logic signed [15:0] h_real,
  output logic signed [15:0] h_imag,
  output logic signed [15:0] Tw_real,
  output logic signed [15:0] Tw_imag,
  input  logic signed [15:0] x_real,
  input  logic signed [15:0] x_imag,
  input  logic signed [15:0] y_real,
  input  logic signed [15:0] y_imag
);

  localparam int LOG2N = $clog2(N);
  localparam int AW    = LOG2N;
  localparam int BW    = LOG2N - 1;
  localparam int DW    = $clog2(BFU_LAT) + 1;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   stage;
  logic [BW-1:0]   bfly;
  logic [DW-1:0]   dcnt;

  logic [BFU_LAT-1:0] tag_v;
  logic [AW-1:0]      tag_top [BFU_LAT];
  logic [AW-1:0]      tag_bot [BFU_LAT];

  sample_t         mem [N];

  logic [AW-1:0]   bfly_ext;
  logic [AW-1:0]   span;
  logic [AW-1:0]   grp_off;
  logic [AW-1:0]   top;
  logic [AW-1:0]   bot;
  logic [BW-1:0]   tw_k;
  logic [AW-1:0]   load_addr;
  sample_t         tw;

  logic            last_bfly;
  logic            last_drain;
  logic            last_stage;
  logic            last_idx;
  logic            issue;
  logic            accept;

  assign last_bfly  = (bfly == BW'(N / 2 - 1));
  assign last_drain = (dcnt == DW'(BFU_LAT - 1));
  assign last_stage = (stage == AW'(LOG2N - 1));
  assign last_idx   = (idx == AW'(N - 1));
  assign issue      = (state == ST_ISSUE);
  assign accept     = (state == ST_LOAD) && in_valid;
  assign load_addr  = AW'(bitrev(addr_t'(idx), LOG2N));

  // Butterfly b of stage s pairs top=(b>>s)*2m+j with bot=top+m, twiddle k=j*N/(2m).
  always_comb begin
    bfly_ext = AW'(bfly);
    span     = AW'(1) << stage;
    grp_off  = bfly_ext & (span - AW'(1));
    top      = ((bfly_ext >> stage) << (stage + AW'(1))) | grp_off;
    bot      = top | span;
    tw_k     = BW'(grp_off << (AW'(LOG2N - 1) - stage));
  end

  fft_twiddle_rom #(
    .N (N)
  ) u_twiddle_rom (
    .k  (tw_k),
    .tw (tw)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (in_valid && last_idx) state_nxt = ST_ISSUE;
      ST_ISSUE:  if (last_bfly) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (last_drain) state_nxt = last_stage ? ST_UNLOAD : ST_ISSUE;
      ST_UNLOAD: if (out_ready && last_idx) state_nxt = ST_LOAD;
      default:   state_nxt = ST_LOAD;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_real  = '0;
    out_imag  = '0;
    bfu_valid = 1'b0;
    g_real    = '0;
    g_imag    = '0;
    h_real    = '0;
    h_imag    = '0;
    Tw_real   = '0;
    Tw_imag   = '0;
    case (state)
      ST_LOAD: in_ready = 1'b1;
      ST_ISSUE: begin
        bfu_valid = 1'b1;
        g_real    = mem[top].re;
        g_imag    = mem[top].im;
        h_real    = mem[bot].re;
        h_imag    = mem[bot].im;
        Tw_real   = tw.re;
        Tw_imag   = tw.im;
      end
      ST_UNLOAD: begin
        out_valid = 1'b1;
        out_last  = last_idx;
        out_real  = mem[idx].re;
        out_imag  = mem[idx].im;
      end
      default: ;
    endcase
  end

  // idx serves as load index and unload index; both runs end by wrapping to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      stage <= '0;
      bfly  <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        ST_LOAD:  if (in_valid) idx <= idx + AW'(1);
        ST_ISSUE: bfly <= bfly + BW'(1);
        ST_DRAIN: begin
          if (last_drain) begin
            dcnt  <= '0;
            stage <= last_stage ? '0 : stage + AW'(1);
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        ST_UNLOAD: if (out_ready) idx <= idx + AW'(1);
        default: ;
      endcase
    end
  end

  // Only the valid bits need reset: they alone decide whether a writeback happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= issue;
      for (int i = 1; i < BFU_LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  // NOTE: the sample store and tag addresses carry no reset; their contents are
  // don't-care until written, and a reset would block a plain register-file mapping.
  always_ff @(posedge clk) begin
    tag_top[0] <= top;
    tag_bot[0] <= bot;
    for (int i = 1; i < BFU_LAT; i++) begin
      tag_top[i] <= tag_top[i-1];
      tag_bot[i] <= tag_bot[i-1];
    end
    if (accept) mem[load_addr] <= '{re: in_real, im: in_imag};
    if (tag_v[BFU_LAT-1]) begin
      mem[tag_top[BFU_LAT-1]] <= '{re: x_real, im: x_imag};
      mem[tag_bot[BFU_LAT-1]] <= '{re: y_real, im: y_imag};
    end
  end

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl (N=8, BFU_LAT=2) with a stub BFU x=g+h, y=g-h.
// A loop-level DIT model predicts every operand triple and every output bin.
module tb_fft_ctrl;

  localparam int    N       = 8;
  localparam int    BFU_LAT = 2;
  localparam int    LOG2N   = 3;
  localparam real   PI      = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready, out_last, bfu_valid;
  logic signed [15:0] in_real, in_imag, out_real, out_imag;
  logic signed [15:0] g_real, g_imag, h_real, h_imag, Tw_real, Tw_imag;
  logic signed [15:0] x_real, x_imag, y_real, y_imag;

  always #5 clk = ~clk;

  fft_ctrl #(
    .N       (N),
    .BFU_LAT (BFU_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_last  (out_last),
    .bfu_valid (bfu_valid),
    .g_real    (g_real),
    .g_imag    (g_imag),
    .h_real    (h_real),
    .h_imag    (h_imag),
    .Tw_real   (Tw_real),
    .Tw_imag   (Tw_imag),
    .x_real    (x_real),
    .x_imag    (x_imag),
    .y_real    (y_real),
    .y_imag    (y_imag)
  );

  // Stub BFU: Tw ignored, BFU_LAT-cycle pipeline.
  logic signed [15:0] xr_p [BFU_LAT], xi_p [BFU_LAT], yr_p [BFU_LAT], yi_p [BFU_LAT];
  always @(posedge clk) begin
    xr_p[0] <= g_real + h_real;
    xi_p[0] <= g_imag + h_imag;
    yr_p[0] <= g_real - h_real;
    yi_p[0] <= g_imag - h_imag;
    for (int i = 1; i < BFU_LAT; i++) begin
      xr_p[i] <= xr_p[i-1];
      xi_p[i] <= xi_p[i-1];
      yr_p[i] <= yr_p[i-1];
      yi_p[i] <= yi_p[i-1];
    end
  end
  assign x_real = xr_p[BFU_LAT-1];
  assign x_imag = xi_p[BFU_LAT-1];
  assign y_real = yr_p[BFU_LAT-1];
  assign y_imag = yi_p[BFU_LAT-1];

  typedef struct packed {
    logic [31:0] g;
    logic [31:0] h;
    logic [31:0] t;
  } ops_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          first_out;
  int          acc_cyc;
  bit          seen_out;
  logic [15:0] in_re [N], in_im [N], exp_re [N], exp_im [N];
  ops_t        exp_ops [$];
  ops_t        obs_ops [$];
  int          issue_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (bfu_valid) begin
        obs_ops.push_back('{g: {g_real, g_imag}, h: {h_real, h_imag}, t: {Tw_real, Tw_imag}});
        issue_cyc.push_back(cyc);
      end
      if (out_valid && !seen_out) begin
        seen_out  <= 1'b1;
        first_out <= cyc;
      end
    end
  end

  function automatic logic [15:0] q15(input real x);
    real v;
    v = $floor(x * 32768.0 + 0.5);
    if (v > 32767.0)  v = 32767.0;
    if (v < -32767.0) v = -32767.0;
    return 16'($rtoi(v));
  endfunction

  function automatic int brev(input int i);
    int r = 0;
    for (int n = 0; n < LOG2N; n++)
      if (((i >> n) & 1) != 0) r |= 1 << (LOG2N - 1 - n);
    return r;
  endfunction

  // Textbook in-place DIT over an array: bit-reversed load, then stages/groups/pairs.
  task automatic build_model();
    logic [15:0] ar [N], ai [N];
    logic [15:0] tr, ti, gr, gi, hr, hi;
    for (int i = 0; i < N; i++) begin
      ar[brev(i)] = in_re[i];
      ai[brev(i)] = in_im[i];
    end
    exp_ops.delete();
    for (int s = 0; s < LOG2N; s++) begin
      int m = 1 << s;
      for (int base = 0; base < N; base += 2 * m) begin
        for (int j = 0; j < m; j++) begin
          int t = base + j;
          int u = t + m;
          int k = j * N / (2 * m);
          tr = q15($cos(2.0 * PI * k / N));
          ti = q15(-$sin(2.0 * PI * k / N));
          exp_ops.push_back('{g: {ar[t], ai[t]}, h: {ar[u], ai[u]}, t: {tr, ti}});
          gr = ar[t]; gi = ai[t]; hr = ar[u]; hi = ai[u];
          ar[t] = gr + hr; ai[t] = gi + hi;
          ar[u] = gr - hr; ai[u] = gi - hi;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_re[i] = ar[i];
      exp_im[i] = ai[i];
    end
  endtask

  task automatic load_frame();
    int i = 0;
    int guard = 0;
    build_model();
    obs_ops.delete();
    issue_cyc.delete();
    seen_out = 1'b0;
    while (i < N && guard < 500) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_real  = 16'($urandom);
        in_imag  = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_real  = in_re[i];
        in_imag  = in_im[i];
        if (in_ready) begin
          i++;
          acc_cyc = cyc;
        end
      end
    end
    if (i < N) check("load_timeout", i, N);
  endtask

  // mode 0: random out_ready, 1: alternating 1/0, 2: always ready.
  task automatic finish_frame(input int mode);
    int  guard = 0;
    int  j = 0;
    bit  busy_hi = 1'b0;
    bit  ph = 1'b1;
    int  lim;
    @(negedge clk);
    while (guard < 300) begin
      if (out_valid) break;
      if (in_ready) busy_hi = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      in_real  = 16'($urandom);
      in_imag  = 16'($urandom);
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("compute_done", out_valid, 1);
    check("in_ready_busy", busy_hi, 0);
    guard = 0;
    while (j < N && guard < 400) begin
      check($sformatf("out_valid[%0d]", j), out_valid, 1);
      check($sformatf("out_data[%0d]", j), {out_real, out_imag}, {exp_re[j], exp_im[j]});
      check($sformatf("out_last[%0d]", j), out_last, (j == N - 1));
      check("in_ready_unload", in_ready, 0);
      case (mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       begin out_ready = ph; ph = !ph; end
        default: out_ready = 1'b1;
      endcase
      if (out_ready && out_valid) j++;
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    check("unload_count", j, N);
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
    check("n_issue", obs_ops.size(), exp_ops.size());
    lim = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
    for (int t = 0; t < lim; t++) begin
      check($sformatf("g[%0d]", t), obs_ops[t].g, exp_ops[t].g);
      check($sformatf("h[%0d]", t), obs_ops[t].h, exp_ops[t].h);
      check($sformatf("tw[%0d]", t), obs_ops[t].t, exp_ops[t].t);
    end
    for (int t = 1; t < issue_cyc.size(); t++)
      check($sformatf("issue_gap[%0d]", t), issue_cyc[t] - issue_cyc[t-1],
            ((t % (N / 2)) == 0) ? BFU_LAT + 1 : 1);
    if (issue_cyc.size() > 0) begin
      check("first_issue", issue_cyc[0], acc_cyc + 1);
      check("latency", first_out - issue_cyc[0], LOG2N * (N / 2 + BFU_LAT));
    end else begin
      check("any_issue", 0, 1);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_bfu_valid"}, bfu_valid, 0);
    check({tag, "_g"}, {g_real, g_imag}, 0);
    check({tag, "_h"}, {h_real, h_imag}, 0);
    check({tag, "_tw"}, {Tw_real, Tw_imag}, 0);
    check({tag, "_out"}, {out_real, out_imag}, 0);
  endtask

  logic [31:0] tw_s2 [4];
  int guard;

  initial begin
    tw_s2 = '{32'h7fff0000, 32'h5a82a57e, 32'h00008001, 32'ha57ea57e};
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_imag = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Ramp input: checks bit-reversed placement and the stage-2 twiddle sequence.
    for (int i = 0; i < N; i++) begin in_re[i] = 16'(i * 256); in_im[i] = '0; end
    load_frame();
    finish_frame(2);
    if (obs_ops.size() >= 12) begin
      check("ramp_g0", obs_ops[0].g[31:16], 16'h0000);
      check("ramp_h0", obs_ops[0].h[31:16], 16'h0400);
      check("ramp_tw0", obs_ops[0].t, 32'h7fff0000);
      check("ramp_g1", obs_ops[1].g[31:16], 16'h0200);
      check("ramp_h1", obs_ops[1].h[31:16], 16'h0600);
      for (int t = 0; t < 4; t++) check($sformatf("s2_tw[%0d]", t), obs_ops[8 + t].t, tw_s2[t]);
    end else begin
      check("ramp_issue_count", obs_ops.size(), 12);
    end

    // Constant 0x0010: bin 0 = 0x0080, remaining bins zero.
    for (int i = 0; i < N; i++) begin in_re[i] = 16'h0010; in_im[i] = '0; end
    load_frame();
    finish_frame(2);

    // Random data with alternating backpressure, then random backpressure.
    for (int i = 0; i < N; i++) begin in_re[i] = 16'($urandom); in_im[i] = 16'($urandom); end
    load_frame();
    finish_frame(1);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) begin in_re[i] = 16'($urandom); in_im[i] = 16'($urandom); end
      load_frame();
      finish_frame(0);
    end

    // Abort during stage 1 issue, then a fresh frame must be unaffected.
    for (int i = 0; i < N; i++) begin in_re[i] = 16'($urandom); in_im[i] = 16'($urandom); end
    load_frame();
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (obs_ops.size() < N / 2 + 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("abort_in_stage1", bfu_valid, 1);
    #2 reset = 1'b0;
    #1 check_idle("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("abort_release");
    for (int i = 0; i < N; i++) begin in_re[i] = 16'h0010; in_im[i] = '0; end
    load_frame();
    finish_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
